// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add multiplier, one multiplier bit per clock, WIDTH-cycle latency.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (radix-2 Booth); unsigned otherwise.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]         state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] out_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH-1:0]   mplier_nxt_s;

`ifdef SEQ_MUL_SIGNED_EN
    logic               prev_r;
    logic [WIDTH:0]     acc_ext_s;
    logic [WIDTH:0]     mcand_ext_s;

    // Booth step: recode {mplier[0], previous bit} into add / subtract / skip.
    always_comb begin
        acc_ext_s   = {acc_r[WIDTH-1], acc_r};
        mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
        case ({mplier_r[0], prev_r})
            2'b01:   sum_s = acc_ext_s + mcand_ext_s;
            2'b10:   sum_s = acc_ext_s - mcand_ext_s;
            default: sum_s = acc_ext_s;
        endcase
    end
`else
    // Unsigned step: conditionally add the zero-extended multiplicand, keeping the carry.
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r};
        end
    end
`endif

    // Right shift of {sum, mplier}; sum[WIDTH] is the carry (unsigned) or sign (Booth).
    always_comb begin
        acc_nxt_s    = sum_s[WIDTH:1];
        mplier_nxt_s = {sum_s[0], mplier_r[WIDTH-1:1]};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_r    <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MUL_SIGNED_EN
            prev_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= A;
                        mplier_r <= B;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
`ifdef SEQ_MUL_SIGNED_EN
                        prev_r   <= 1'b0;
`endif
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r    <= acc_nxt_s;
                    mplier_r <= mplier_nxt_s;
`ifdef SEQ_MUL_SIGNED_EN
                    prev_r   <= mplier_r[0];
`endif
                    // Start is deliberately not looked at here: requests while busy are dropped.
                    if (cnt_r == CNT_LAST) begin
                        out_r   <= {acc_nxt_s, mplier_nxt_s};
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=8 (handshake, corner products, abort).
module tb_seq_mul;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, WIDTH-1 busy cycles, done pulse, pulse drop.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [2*W-1:0] exp);
        int bad;
        bad = 0;
        a = ai;
        b = bi;
        start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            step();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk({tag, "_run_window"}, 32'(bad), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_out"}, 32'(out), 32'(exp));
        step();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_out_hold"}, 32'(out), 32'(exp));
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        #3 rst_n = 1'b1;
        step();

        run_op("mul_2x3", 8'd2, 8'd3, 16'h0006);
`ifdef SEQ_MUL_SIGNED_EN
        run_op("s_m1xm1", 8'hFF, 8'hFF, 16'h0001);
        run_op("s_80x7F", 8'h80, 8'h7F, 16'hC080);
        run_op("s_80x80", 8'h80, 8'h80, 16'h4000);
`else
        run_op("u_FFx01", 8'hFF, 8'h01, 16'h00FF);
        run_op("u_AAx55", 8'hAA, 8'h55, 16'h3872);
        run_op("u_FFxFF", 8'hFF, 8'hFF, 16'hFE01);
        run_op("u_00xFF", 8'h00, 8'hFF, 16'h0000);
`endif

        // Busy protection: a start pulse sampled at RUN edge 3 must be dropped.
        a = 8'd5;
        b = 8'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        a = '0;
        b = '0;
        bad = 0;
        repeat (4) begin
            step();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk("prot_run_window", 32'(bad), 32'd0);
        step();
        chk("prot_done", 32'(done), 32'd1);
        chk("prot_out", 32'(out), 32'h001E);
        bad = 0;
        repeat (12) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h001E) bad++;
        end
        chk("prot_no_second_op", 32'(bad), 32'd0);

        // Back-to-back with start held high across the done cycle.
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        step();
        chk("b2b_busy1", 32'(busy), 32'd1);
        repeat (7) step();
        step();
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_out1", 32'(out), 32'h003F);
        a = 8'h10;
        b = 8'h10;
        step();
        start = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        bad = 0;
        repeat (7) begin
            step();
            if (done !== 1'b0 || out !== 16'h003F) bad++;
        end
        chk("b2b_hold", 32'(bad), 32'd0);
        step();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_out2", 32'(out), 32'h0100);
        step();
        chk("b2b_done2_drop", 32'(done), 32'd0);

        // Asynchronous reset in the middle of RUN.
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        step();
        step();
        #3 rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) bad++;
        end
        chk("abort_idle_wait", 32'(bad), 32'd0);
        run_op("after_abort_3x4", 8'd3, 8'd4, 16'h000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-add multiplier: replaces the fully combinational array multiplier where area matters more than latency. Accepts one WIDTH x WIDTH operand pair per start pulse and iterates one multiplier bit per clock. It registers a 2*WIDTH-bit product and signals completion with a one-cycle done pulse. It sits in the arithmetic library alongside the array multipliers and shares their operand/product widths at WIDTH=8.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; clears all registers immediately.
- start  input  1  request; sampled on rising clk; accepted only in IDLE.
- A  input  WIDTH  multiplicand; captured on the accepting edge.
- B  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; product valid and updated in the same cycle.
- out  output  2*WIDTH  last completed product; holds until the next completion.

## Operation

- States: IDLE, RUN. Reset state IDLE.
- IDLE, start=1: latch A into mcand, latch B into mplier, clear accumulator, clear bit counter, go to RUN. If start=0, stay in IDLE.
- RUN, each cycle:
  - if mplier[0]=1, add mcand (zero-extended) into the upper WIDTH+1 bits of the accumulator;
  - shift {carry, accumulator, mplier} right by one;
  - increment the counter.
- RUN, when the counter reaches WIDTH-1:
  - process the final bit as above;
  - load the finished value into out;
  - set done=1;
  - go to IDLE.
- Counter width is $clog2(WIDTH); the comparison is against WIDTH-1, so there is no wrap-around.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- A and B may change freely after the accepting edge.
- The product is exact and never truncates: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.

## Timing

- Reset values: busy=0, done=0, out=0, state IDLE, internal registers 0.
- start sampled high at edge N (IDLE):
  - busy=1 from edge N through edge N+WIDTH;
  - at edge N+WIDTH, out updates, done=1 and busy=0 for exactly one cycle.
- Latency is WIDTH cycles from the accepting edge to done.
- Back-to-back: start asserted in the done cycle is accepted, since the state is already IDLE. Maximum throughput is one operation per WIDTH+1 cycles.
- Continuously held start re-triggers on every IDLE cycle.
- rst_n low mid-RUN:
  - aborts immediately;
  - out clears to 0;
  - no done pulse.
  - After rst_n deasserts, the block waits in IDLE for a new start.

## Configuration

- SEQ_MUL_SIGNED_EN defined: A, B and out are two's complement.
  - The multiplier uses radix-2 Booth recoding over {mplier, 1'b0}: pair 01 adds mcand, pair 10 subtracts mcand, 00/11 do nothing.
  - The accumulator shift is arithmetic (sign-extending).
  - Latency and handshake are identical to unsigned mode.
- SEQ_MUL_SIGNED_EN undefined: unsigned shift-add as described in Operation.
- In both modes the product is the exact 2*WIDTH-bit result.

## Test plan

- WIDTH=8, unsigned: reset, then A=2, B=3, start for 1 cycle -> busy for 8 cycles, done pulse exactly 8 cycles after the accepting edge, out=16'h0006.
- Unsigned corner products, each followed by a done check:
  - A=8'hFF, B=8'h01 -> out=16'h00FF;
  - A=8'hAA, B=8'h55 -> out=16'h3872;
  - A=8'hFF, B=8'hFF -> out=16'hFE01;
  - A=8'h00, B=8'hFF -> out=16'h0000.
- Busy protection: start A=5, B=6; at cycle 3 of RUN pulse start with A=8'hFF, B=8'hFF -> still a single done pulse with out=16'h001E, and no second operation begins.
- Back-to-back: hold start high with A=7, B=9, then A=8'h10, B=8'h10 -> done pulses 9 cycles apart, out=16'h003F then 16'h0100, and out holds between pulses.
- Reset mid-operation: start A=8'hFF, B=8'hFF, drive rst_n low at RUN cycle 4 (asynchronous, between edges) -> busy, done and out are 0 immediately. After release, no done occurs until a new start; the next op A=3, B=4 gives out=16'h000C.
- With SEQ_MUL_SIGNED_EN:
  - A=8'hFF, B=8'hFF (-1*-1) -> out=16'h0001;
  - A=8'h80, B=8'h7F -> out=16'hC080;
  - A=8'h80, B=8'h80 -> out=16'h4000;
  - all with latency 8.
